// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one req/addr_ok/data_ok memory port between an instruction
//   requester (ID 0) and a data requester (ID 1).
//   - Round-robin arbitration between eligible requesters. A read is only
//     eligible while fewer than OUTSTANDING reads await data.
//   - A forwarded request that is stalled (s_addr_ok=0) locks the port to
//     that requester until it is accepted or drops req.
//   - Accepted reads push their requester ID into an in-order FIFO. Each
//     s_data_ok pops the head and is steered to that requester.
//   - err is sticky. It is set when s_data_ok arrives with nothing outstanding.
// Ports
//   clk, rst_n                      : clock, asynchronous active-low reset
//   i_req/i_write/i_wstrb/i_addr/i_wdata : instruction requester request
//   i_addr_ok/i_data_ok/i_rdata     : instruction requester responses
//   d_req/d_write/d_wstrb/d_addr/d_wdata : data requester request
//   d_addr_ok/d_data_ok/d_rdata     : data requester responses
//   s_req/s_write/s_wstrb/s_addr/s_wdata : shared memory port request
//   s_addr_ok/s_data_ok/s_rdata     : shared memory port responses
//   err                             : sticky unexpected-response flag
module mem_arbiter #(
  parameter int AW          = 12,
  parameter int DW          = 32,
  parameter int OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req,
  input  logic            i_write,
  input  logic [DW/8-1:0] i_wstrb,
  input  logic [AW-1:0]   i_addr,
  input  logic [DW-1:0]   i_wdata,
  output logic            i_addr_ok,
  output logic            i_data_ok,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_write,
  input  logic [DW/8-1:0] d_wstrb,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_addr_ok,
  output logic            d_data_ok,
  output logic [DW-1:0]   d_rdata,
  output logic            s_req,
  output logic            s_write,
  output logic [DW/8-1:0] s_wstrb,
  output logic [AW-1:0]   s_addr,
  output logic [DW-1:0]   s_wdata,
  input  logic            s_addr_ok,
  input  logic            s_data_ok,
  input  logic [DW-1:0]   s_rdata,
  output logic            err
);

  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

  logic [CW-1:0] count_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic          id_fifo_reg [OUTSTANDING];
  logic          lock_reg;
  logic          lock_id_reg;
  logic          last_grant_reg;
  logic          err_reg;

  logic room;
  logic i_elig;
  logic d_elig;
  logic win_valid;
  logic win_id;
  logic fwd;
  logic accept;
  logic push;
  logic pop;
  logic head_id;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Writes never occupy a FIFO slot, so they stay eligible when the FIFO is full.
  assign room   = (count_reg < CW'(OUTSTANDING));
  assign i_elig = i_req & (i_write | room);
  assign d_elig = d_req & (d_write | room);

  always_comb begin
    win_valid = 1'b0;
    win_id    = 1'b0;
    if (lock_reg) begin
      // A stalled request keeps the port. If its req drops, nothing is
      // forwarded and the lock clears at the next edge.
      win_id    = lock_id_reg;
      win_valid = lock_id_reg ? d_req : i_req;
    end else if (i_elig && d_elig) begin
      win_valid = 1'b1;
      win_id    = ~last_grant_reg;
    end else if (i_elig) begin
      win_valid = 1'b1;
      win_id    = 1'b0;
    end else if (d_elig) begin
      win_valid = 1'b1;
      win_id    = 1'b1;
    end
  end

  // Reset forces the port and all handshakes quiet immediately.
  assign fwd     = win_valid & rst_n;
  assign s_req   = fwd;
  assign s_write = fwd & (win_id ? d_write : i_write);
  assign s_wstrb = fwd ? (win_id ? d_wstrb : i_wstrb) : '0;
  assign s_addr  = fwd ? (win_id ? d_addr  : i_addr)  : '0;
  assign s_wdata = fwd ? (win_id ? d_wdata : i_wdata) : '0;

  assign accept    = fwd & s_addr_ok;
  assign i_addr_ok = accept & ~win_id;
  assign d_addr_ok = accept &  win_id;

  assign push    = accept & ~s_write;
  assign pop     = s_data_ok & (count_reg != '0);
  assign head_id = id_fifo_reg[rd_ptr_reg];

  assign i_data_ok = rst_n & pop & ~head_id;
  assign d_data_ok = rst_n & pop &  head_id;
  assign i_rdata   = s_rdata;
  assign d_rdata   = s_rdata;
  assign err       = err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg      <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      lock_reg       <= 1'b0;
      lock_id_reg    <= 1'b0;
      last_grant_reg <= 1'b1;
      err_reg        <= 1'b0;
      for (int k = 0; k < OUTSTANDING; k++) begin
        id_fifo_reg[k] <= 1'b0;
      end
    end else begin
      // Lock while a forwarded request is stalled. Clears on acceptance or req drop.
      lock_reg    <= fwd & ~s_addr_ok;
      lock_id_reg <= win_id;

      if (accept) begin
        last_grant_reg <= win_id;
      end

      if (push) begin
        id_fifo_reg[wr_ptr_reg] <= win_id;
        wr_ptr_reg              <= ptr_inc(wr_ptr_reg);
      end

      // The pop reads the head before this cycle's push lands.
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end

      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase

      if (s_data_ok && (count_reg == '0)) begin
        err_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. A queue-based reference model
// predicts every output on every cycle. Directed scenarios add literal
// expectations on top of the model. A randomized phase follows.
module tb_mem_arbiter;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int OUTST = 2;

  logic          clk;
  logic          rst_n;
  logic          i_req, i_write;
  logic [SW-1:0] i_wstrb;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_wdata;
  logic          i_addr_ok, i_data_ok;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_write;
  logic [SW-1:0] d_wstrb;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_addr_ok, d_data_ok;
  logic [DW-1:0] d_rdata;
  logic          s_req, s_write;
  logic [SW-1:0] s_wstrb;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic          s_addr_ok, s_data_ok;
  logic [DW-1:0] s_rdata;
  logic          err;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  bit mq[$];      // requester IDs of outstanding reads, oldest first
  bit m_lock;
  bit m_lock_id;
  bit m_last;
  bit m_err;

  mem_arbiter #(.AW(AW), .DW(DW), .OUTSTANDING(OUTST)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_write(i_write), .i_wstrb(i_wstrb), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_write(d_write), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .s_req(s_req), .s_write(s_write), .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_lock    = 1'b0;
    m_lock_id = 1'b0;
    m_last    = 1'b1;
    m_err     = 1'b0;
  endtask

  // Who owns the port this cycle, derived from the arbitration rules.
  task automatic model_eval(output bit has, output bit win);
    bit ie, de;
    ie  = i_req && (i_write || mq.size() < OUTST);
    de  = d_req && (d_write || mq.size() < OUTST);
    has = 1'b0;
    win = 1'b0;
    if (m_lock) begin
      win = m_lock_id;
      has = win ? d_req : i_req;
    end else if (ie && de) begin
      has = 1'b1;
      win = !m_last;
    end else if (ie) begin
      has = 1'b1;
    end else if (de) begin
      has = 1'b1;
      win = 1'b1;
    end
  endtask

  task automatic model_update();
    bit has, win, wr;
    model_eval(has, win);
    wr = win ? d_write : i_write;
    if (s_data_ok) begin
      if (mq.size() > 0) void'(mq.pop_front());
      else m_err = 1'b1;
    end
    if (has && s_addr_ok) begin
      m_last = win;
      if (!wr) mq.push_back(win);
    end
    m_lock    = has && !s_addr_ok;
    m_lock_id = win;
  endtask

  // Compare every DUT output against the model, 1 ns after inputs settle.
  task automatic check();
    bit has, win, pop, head;
    #1;
    model_eval(has, win);
    if (!rst_n) begin
      cmp("rst_s_req", 64'(s_req), 64'(0));
      cmp("rst_i_addr_ok", 64'(i_addr_ok), 64'(0));
      cmp("rst_d_addr_ok", 64'(d_addr_ok), 64'(0));
      cmp("rst_i_data_ok", 64'(i_data_ok), 64'(0));
      cmp("rst_d_data_ok", 64'(d_data_ok), 64'(0));
      cmp("rst_err", 64'(err), 64'(0));
    end else begin
      pop  = s_data_ok && (mq.size() > 0);
      head = (mq.size() > 0) ? mq[0] : 1'b0;
      cmp("s_req", 64'(s_req), 64'(has));
      cmp("s_write", 64'(s_write), has ? 64'(win ? d_write : i_write) : 64'(0));
      cmp("s_wstrb", 64'(s_wstrb), has ? 64'(win ? d_wstrb : i_wstrb) : 64'(0));
      cmp("s_addr", 64'(s_addr), has ? 64'(win ? d_addr : i_addr) : 64'(0));
      cmp("s_wdata", 64'(s_wdata), has ? 64'(win ? d_wdata : i_wdata) : 64'(0));
      cmp("i_addr_ok", 64'(i_addr_ok), 64'(has && !win && s_addr_ok));
      cmp("d_addr_ok", 64'(d_addr_ok), 64'(has && win && s_addr_ok));
      cmp("i_data_ok", 64'(i_data_ok), 64'(pop && !head));
      cmp("d_data_ok", 64'(d_data_ok), 64'(pop && head));
      cmp("err", 64'(err), 64'(m_err));
    end
    cmp("i_rdata", 64'(i_rdata), 64'(s_rdata));
    cmp("d_rdata", 64'(d_rdata), 64'(s_rdata));
  endtask

  // Advance one cycle: update the model at the edge, return on the next negedge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    i_req = 0; i_write = 0; i_wstrb = '0; i_addr = '0; i_wdata = '0;
    d_req = 0; d_write = 0; d_wstrb = '0; d_addr = '0; d_wdata = '0;
    s_addr_ok = 0; s_data_ok = 0; s_rdata = '0;
  endtask

  task automatic set_i(input logic rq, input logic wr, input logic [AW-1:0] a);
    i_req = rq; i_write = wr; i_addr = a; i_wstrb = SW'(4'hF); i_wdata = DW'(32'h1000) + DW'(a);
  endtask

  task automatic set_d(input logic rq, input logic wr, input logic [AW-1:0] a);
    d_req = rq; d_write = wr; d_addr = a; d_wstrb = SW'(4'h3); d_wdata = DW'(32'h2000) + DW'(a);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    model_reset();
    check();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();

    // Reset state
    do_reset();
    check();
    cmp("lit_reset_err", 64'(err), 64'(0));
    cmp("lit_reset_s_req", 64'(s_req), 64'(0));

    // Both reads, s_addr_ok always high: grants alternate I,D,I,D
    set_i(1, 0, 12'h100); set_d(1, 0, 12'h200); s_addr_ok = 1; s_rdata = 32'hA0;
    check();
    cmp("lit_rr1_i_addr_ok", 64'(i_addr_ok), 64'(1));
    cmp("lit_rr1_s_addr", 64'(s_addr), 64'(12'h100));
    tick();
    s_data_ok = 1; s_rdata = 32'hA1;
    check();
    cmp("lit_rr2_d_addr_ok", 64'(d_addr_ok), 64'(1));
    cmp("lit_rr2_i_data_ok", 64'(i_data_ok), 64'(1));
    tick();
    check();
    cmp("lit_rr3_i_addr_ok", 64'(i_addr_ok), 64'(1));
    cmp("lit_rr3_d_data_ok", 64'(d_data_ok), 64'(1));
    tick();
    check();
    cmp("lit_rr4_d_addr_ok", 64'(d_addr_ok), 64'(1));
    cmp("lit_rr4_i_data_ok", 64'(i_data_ok), 64'(1));
    tick();
    idle(); s_data_ok = 1;
    check();
    cmp("lit_rr5_d_data_ok", 64'(d_data_ok), 64'(1));
    tick();

    // Lock: stalled data write holds the port while instr requests
    idle(); set_d(1, 1, 12'h345);
    check();
    cmp("lit_lock1_s_addr", 64'(s_addr), 64'(12'h345));
    tick();
    set_i(1, 0, 12'h011);
    check();
    cmp("lit_lock2_s_addr", 64'(s_addr), 64'(12'h345));
    cmp("lit_lock2_i_addr_ok", 64'(i_addr_ok), 64'(0));
    tick();
    s_addr_ok = 1;
    check();
    cmp("lit_lock3_d_addr_ok", 64'(d_addr_ok), 64'(1));
    cmp("lit_lock3_s_addr", 64'(s_addr), 64'(12'h345));
    tick();
    set_d(0, 0, 12'h0);
    check();
    cmp("lit_lock4_i_addr_ok", 64'(i_addr_ok), 64'(1));
    tick();
    idle(); s_data_ok = 1;
    check();
    cmp("lit_lock5_i_data_ok", 64'(i_data_ok), 64'(1));
    tick();

    // Fill to OUTSTANDING reads; a further read is blocked, a write passes
    idle(); set_i(1, 0, 12'h021); s_addr_ok = 1;
    check(); tick();
    set_i(1, 0, 12'h022);
    check(); tick();
    set_d(1, 1, 12'h0F0);
    check();
    cmp("lit_full_d_addr_ok", 64'(d_addr_ok), 64'(1));
    cmp("lit_full_i_addr_ok", 64'(i_addr_ok), 64'(0));
    cmp("lit_full_s_write", 64'(s_write), 64'(1));
    tick();
    set_d(0, 0, 12'h0);
    check();
    cmp("lit_full_s_req", 64'(s_req), 64'(0));
    tick();

    // Pops with pushes in the same cycle keep issue order across wrap
    idle(); set_d(1, 0, 12'h0D1); s_addr_ok = 1; s_data_ok = 1;
    check();
    cmp("lit_pp1_s_req", 64'(s_req), 64'(0));
    cmp("lit_pp1_i_data_ok", 64'(i_data_ok), 64'(1));
    tick();
    check();
    cmp("lit_pp2_d_addr_ok", 64'(d_addr_ok), 64'(1));
    cmp("lit_pp2_i_data_ok", 64'(i_data_ok), 64'(1));
    tick();
    set_d(0, 0, 12'h0); set_i(1, 0, 12'h0E1);
    check();
    cmp("lit_pp3_i_addr_ok", 64'(i_addr_ok), 64'(1));
    cmp("lit_pp3_d_data_ok", 64'(d_data_ok), 64'(1));
    tick();
    idle(); s_data_ok = 1;
    check();
    cmp("lit_pp4_i_data_ok", 64'(i_data_ok), 64'(1));
    tick();

    // Unexpected response sets sticky err
    idle(); s_data_ok = 1;
    check();
    cmp("lit_err_i_data_ok", 64'(i_data_ok), 64'(0));
    cmp("lit_err_d_data_ok", 64'(d_data_ok), 64'(0));
    tick();
    s_data_ok = 0;
    check();
    cmp("lit_err_set", 64'(err), 64'(1));
    tick();
    check();
    cmp("lit_err_sticky", 64'(err), 64'(1));

    // Asynchronous reset with two reads outstanding
    do_reset();
    check();
    cmp("lit_rst2_err", 64'(err), 64'(0));
    set_i(1, 0, 12'h031); s_addr_ok = 1;
    check(); tick();
    set_i(0, 0, 12'h0); set_d(1, 0, 12'h032);
    check(); tick();
    set_i(1, 0, 12'h033); set_d(1, 1, 12'h034); s_data_ok = 1;
    check();
    rst_n = 1'b0;
    model_reset();
    check();
    cmp("lit_async_s_req", 64'(s_req), 64'(0));
    cmp("lit_async_i_data_ok", 64'(i_data_ok), 64'(0));
    cmp("lit_async_addr_ok", 64'(i_addr_ok | d_addr_ok), 64'(0));
    tick();
    rst_n = 1'b1;
    idle(); s_data_ok = 1;
    check();
    cmp("lit_late_data_ok", 64'(i_data_ok | d_data_ok), 64'(0));
    tick();
    s_data_ok = 0;
    check();
    cmp("lit_late_err", 64'(err), 64'(1));
    tick();

    // Randomized traffic; a locked requester keeps its request stable
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if (!(m_lock && m_lock_id == 1'b0)) begin
        i_req   = ($urandom_range(0, 9) < 6);
        i_write = ($urandom_range(0, 2) == 0);
        i_wstrb = SW'($urandom);
        i_addr  = AW'($urandom);
        i_wdata = DW'($urandom);
      end
      if (!(m_lock && m_lock_id == 1'b1)) begin
        d_req   = ($urandom_range(0, 9) < 6);
        d_write = ($urandom_range(0, 2) == 0);
        d_wstrb = SW'($urandom);
        d_addr  = AW'($urandom);
        d_wdata = DW'($urandom);
      end
      s_addr_ok = ($urandom_range(0, 1) == 1);
      s_data_ok = ($urandom_range(0, 3) == 0);
      s_rdata   = DW'($urandom);
      check();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
